// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array edge feeder and the array top.
// Holds the default array geometry and the feeder FSM state encoding.
package systolic_feeder_pkg;

  localparam int ROWS_DEF       = 4;
  localparam int COLS_DEF       = 4;
  localparam int PORT_WIDTH_DEF = 8;
  localparam int ROW_SKEW_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } feeder_state_t;

  // Cycles needed for the bottom row's last element to leave its skew line.
  function automatic int flush_cycles(input int rows, input int skew);
    return (rows - 1) * skew + 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// Fixed-length delay line with asynchronous clear; DEPTH=0 degenerates to a wire.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe <= '0;
        end else begin
          pipe[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
          end
        end
      end

      assign q = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// West/north edge feeder: preloads weight rows into the column chains, then
// streams activation vectors into the array rows with per-row skew.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int ROWS       = ROWS_DEF,
  parameter int COLS       = COLS_DEF,
  parameter int PORT_WIDTH = PORT_WIDTH_DEF,
  parameter int ROW_SKEW   = ROW_SKEW_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [COLS*PORT_WIDTH-1:0] w_data,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [ROWS*PORT_WIDTH-1:0] act_data,
  input  logic                       act_last,
  output logic                       pe_mode,
  output logic [COLS*PORT_WIDTH-1:0] pe_weight,
  output logic [ROWS*PORT_WIDTH-1:0] pe_a,
  output logic [ROWS-1:0]            pe_a_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int FLUSH_LEN = flush_cycles(ROWS, ROW_SKEW);
  localparam int CNT_MAX   = (FLUSH_LEN > ROWS) ? FLUSH_LEN : ROWS;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(FLUSH_LEN - 1);

  feeder_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic w_ready_q, act_ready_q, pe_mode_q;
  logic [COLS*PORT_WIDTH-1:0] pe_weight_q;
  logic [ROWS-1:0][PORT_WIDTH-1:0] pe_a_q;
  logic [ROWS-1:0] pe_a_valid_q;

  logic w_acc, a_acc;
  logic [ROWS-1:0][PORT_WIDTH:0] skew_in, skew_out;

  assign w_acc = w_valid && w_ready_q;
  assign a_acc = act_valid && act_ready_q;

  // One counter serves as the weight beat index in LOAD and the drain timer in FLUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (w_acc) begin
          if (ROWS == 1) begin
            state_n = STREAM;
            cnt_n   = '0;
          end else begin
            state_n = LOAD;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      LOAD: begin
        if (w_acc) begin
          if (cnt == LAST_BEAT) begin
            state_n = STREAM;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      STREAM: begin
        if (a_acc && act_last) begin
          state_n = FLUSH;
          cnt_n   = '0;
        end
      end
      FLUSH: begin
        if (cnt == LAST_FLUSH) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Non-accepted cycles feed zero bubbles so the drain side sees clean gaps.
  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign skew_in[r] = a_acc ? {1'b1, act_data[r*PORT_WIDTH +: PORT_WIDTH]} : '0;

      skew_line #(
        .DEPTH(r * ROW_SKEW),
        .WIDTH(PORT_WIDTH + 1)
      ) u_skew (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (skew_in[r]),
        .q    (skew_out[r])
      );
    end
  endgenerate

  // Readies are registered from the next state so they reset to 0 with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ready_q    <= 1'b0;
      act_ready_q  <= 1'b0;
      pe_mode_q    <= 1'b0;
      pe_weight_q  <= '0;
      pe_a_q       <= '0;
      pe_a_valid_q <= '0;
    end else begin
      w_ready_q   <= (state_n == IDLE) || (state_n == LOAD);
      act_ready_q <= (state_n == STREAM);
      pe_mode_q   <= w_acc;
      if (w_acc) begin
        pe_weight_q <= w_data;
      end
      for (int r = 0; r < ROWS; r++) begin
        pe_a_q[r]       <= skew_out[r][PORT_WIDTH-1:0];
        pe_a_valid_q[r] <= skew_out[r][PORT_WIDTH];
      end
    end
  end

  assign w_ready    = w_ready_q;
  assign act_ready  = act_ready_q;
  assign pe_mode    = pe_mode_q;
  assign pe_weight  = pe_weight_q;
  assign pe_a       = pe_a_q;
  assign pe_a_valid = pe_a_valid_q;
  assign busy       = (state != IDLE);
  assign done       = (state == FLUSH) && (cnt == LAST_FLUSH);

endmodule
